// File: rtl/sequenciador_banco_if.sv
// Bundle between the register-bank sequencer and its environment: the
// instruction handshake from fetch, the status outputs and the 8x8 bank ports.
// The master view belongs to the sequencer; the slave view to fetch and the bank.
interface sequenciador_banco_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int INSTR_W = 16
);
  // instruction handshake
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;

  // status
  logic               busy;
  logic               done;
  logic               erro;
  logic               flag_z;
  logic               flag_c;

  // register bank ports
  logic [ADDR_W-1:0]  addR1;
  logic [ADDR_W-1:0]  addR2;
  logic [DATA_W-1:0]  dadoR1;
  logic [DATA_W-1:0]  dadoR2;
  logic               wrEn;
  logic [ADDR_W-1:0]  addWr;
  logic [DATA_W-1:0]  dadoWr;

  modport master (
    input  instr_valid, instr, dadoR1, dadoR2,
    output instr_ready, busy, done, erro, flag_z, flag_c,
           addR1, addR2, wrEn, addWr, dadoWr
  );

  modport slave (
    output instr_valid, instr, dadoR1, dadoR2,
    input  instr_ready, busy, done, erro, flag_z, flag_c,
           addR1, addR2, wrEn, addWr, dadoWr
  );
endinterface

// File: rtl/sequenciador_banco.sv
// Register-bank sequencer: runs one register-to-register instruction at a
// time through a fixed four-cycle pass over the 8x8 bank (registered reads,
// synchronous write).
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | ready for an instruction; on accept latch it, drive rs1/rs2
// LEITURA  | read addresses stable, bank samples them at the end
// EXECUTA  | bank data valid, compute result, register write port/flags
// ESCRITA  | wrEn high (if the op writes), done/erro pulse, back to IDLE
module sequenciador_banco #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int INSTR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  sequenciador_banco_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LEITURA = 2'd1,
    S_EXECUTA = 2'd2,
    S_ESCRITA = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_LDI = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;

  state_t              state_q;
  logic [3:0]          op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [7:0]          imm_q;
  logic [ADDR_W-1:0]   addr1_q;
  logic [ADDR_W-1:0]   addr2_q;
  logic [ADDR_W-1:0]   addr_wr_q;
  logic [DATA_W-1:0]   dado_wr_q;
  logic                wr_en_q;
  logic                busy_q;
  logic                done_q;
  logic                erro_q;
  logic                flag_z_q;
  logic                flag_c_q;

  logic [DATA_W-1:0]   result_d;
  logic                carry_d;
  logic                writes_d;
  logic                flags_upd_d;
  logic                illegal_d;
  logic [DATA_W:0]     sum_w;
  logic [DATA_W:0]     diff_w;

  // Ready is the only combinational output; it falls with reset immediately.
  assign bus.instr_ready = (state_q == S_IDLE) & rst;

  assign bus.addR1  = addr1_q;
  assign bus.addR2  = addr2_q;
  assign bus.addWr  = addr_wr_q;
  assign bus.dadoWr = dado_wr_q;
  assign bus.wrEn   = wr_en_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.erro   = erro_q;
  assign bus.flag_z = flag_z_q;
  assign bus.flag_c = flag_c_q;

  // ALU: result, carry/borrow and write/flag qualifiers from latched op and bank data.
  always_comb begin
    sum_w       = {1'b0, bus.dadoR1} + {1'b0, bus.dadoR2};
    diff_w      = {1'b0, bus.dadoR1} - {1'b0, bus.dadoR2};
    result_d    = '0;
    carry_d     = 1'b0;
    writes_d    = 1'b0;
    flags_upd_d = 1'b1;
    illegal_d   = 1'b0;
    case (op_q)
      OP_NOP: flags_upd_d = 1'b0;
      OP_ADD: begin
        result_d = sum_w[DATA_W-1:0];
        carry_d  = sum_w[DATA_W];
        writes_d = 1'b1;
      end
      OP_SUB: begin
        // the extra bit of the widened difference is the unsigned borrow
        result_d = diff_w[DATA_W-1:0];
        carry_d  = diff_w[DATA_W];
        writes_d = 1'b1;
      end
      OP_AND: begin
        result_d = bus.dadoR1 & bus.dadoR2;
        writes_d = 1'b1;
      end
      OP_OR: begin
        result_d = bus.dadoR1 | bus.dadoR2;
        writes_d = 1'b1;
      end
      OP_XOR: begin
        result_d = bus.dadoR1 ^ bus.dadoR2;
        writes_d = 1'b1;
      end
      OP_MOV: begin
        result_d = bus.dadoR1;
        writes_d = 1'b1;
      end
      OP_LDI: begin
        result_d = DATA_W'(imm_q);
        writes_d = 1'b1;
      end
      OP_CMP: begin
        result_d = diff_w[DATA_W-1:0];
        carry_d  = diff_w[DATA_W];
      end
      default: begin
        flags_upd_d = 1'b0;
        illegal_d   = 1'b1;
      end
    endcase
  end

  // Sequencer FSM with all outputs registered; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NOP;
      rd_q      <= '0;
      imm_q     <= '0;
      addr1_q   <= '0;
      addr2_q   <= '0;
      addr_wr_q <= '0;
      dado_wr_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      erro_q    <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
          erro_q  <= 1'b0;
          if (bus.instr_valid) begin
            op_q    <= bus.instr[15:12];
            rd_q    <= ADDR_W'(bus.instr[11:9]);
            imm_q   <= bus.instr[7:0];
            addr1_q <= ADDR_W'(bus.instr[8:6]);
            addr2_q <= ADDR_W'(bus.instr[5:3]);
            busy_q  <= 1'b1;
            state_q <= S_LEITURA;
          end
        end
        S_LEITURA: begin
          state_q <= S_EXECUTA;
        end
        S_EXECUTA: begin
          addr_wr_q <= rd_q;
          dado_wr_q <= result_d;
          wr_en_q   <= writes_d;
          done_q    <= 1'b1;
          erro_q    <= illegal_d;
          if (flags_upd_d) begin
            flag_z_q <= (result_d == '0);
            flag_c_q <= carry_d;
          end
          state_q <= S_ESCRITA;
        end
        S_ESCRITA: begin
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
          erro_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_banco.sv
// Directed bench for the register-bank sequencer with a behavioural 8x8 bank
// (registered reads, synchronous write, Rn=n at start).
module tb_sequenciador_banco;

  logic clk = 1'b0;
  logic rst;
  logic bank_init;
  logic [7:0] bank [8];

  int n_cmp = 0;
  int n_err = 0;

  int wr_cnt, wr_cyc, done_cnt, done_cyc, erro_cnt, erro_cyc, rdy_cyc;
  logic       busy1;
  logic [2:0] c_addr;
  logic [7:0] c_dado;
  logic       c_z, c_c;

  always #5 clk = ~clk;

  sequenciador_banco_if #(.DATA_W(8), .ADDR_W(3), .INSTR_W(16)) bus_if ();

  sequenciador_banco #(.DATA_W(8), .ADDR_W(3), .INSTR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // behavioural register bank
  always @(posedge clk) begin
    if (bank_init) begin
      for (int i = 0; i < 8; i++) bank[i] <= 8'(i);
    end else begin
      bus_if.dadoR1 <= bank[bus_if.addR1];
      bus_if.dadoR2 <= bank[bus_if.addR2];
      if (bus_if.wrEn) bank[bus_if.addWr] <= bus_if.dadoWr;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] enc_ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {4'h7, rd, 1'b0, imm};
  endfunction

  // Called right after the accepting edge; watches LEITURA, EXECUTA, ESCRITA, IDLE.
  task automatic observe(input bit hold, input logic [15:0] nxt);
    wr_cnt = 0; wr_cyc = 0; done_cnt = 0; done_cyc = 0;
    erro_cnt = 0; erro_cyc = 0; rdy_cyc = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        busy1 = bus_if.busy;
        if (hold) bus_if.instr = nxt;
        else      bus_if.instr_valid = 1'b0;
      end
      if (bus_if.wrEn) begin
        wr_cnt++; wr_cyc = k; c_addr = bus_if.addWr; c_dado = bus_if.dadoWr;
      end
      if (bus_if.done) begin done_cnt++; done_cyc = k; end
      if (bus_if.erro) begin erro_cnt++; erro_cyc = k; end
      if (bus_if.instr_ready && rdy_cyc == 0) rdy_cyc = k;
      if (k == 3) begin c_z = bus_if.flag_z; c_c = bus_if.flag_c; end
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bus_if.instr_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, bus_if.instr_ready, 1);
  endtask

  task automatic issue(input logic [15:0] ins, input bit hold, input logic [15:0] nxt);
    @(negedge clk);
    bus_if.instr_valid = 1'b1;
    bus_if.instr = ins;
    wait_ready("accept");
    @(posedge clk);
    observe(hold, nxt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bank_init = 1'b1;
    bus_if.instr_valid = 1'b0;
    bus_if.instr = '0;
    repeat (3) @(negedge clk);
    check_val("rst_ready",  bus_if.instr_ready, 0);
    check_val("rst_wren",   bus_if.wrEn, 0);
    check_val("rst_busy",   bus_if.busy, 0);
    check_val("rst_done",   bus_if.done, 0);
    check_val("rst_erro",   bus_if.erro, 0);
    check_val("rst_flags",  {bus_if.flag_z, bus_if.flag_c}, 0);
    check_val("rst_addr",   {bus_if.addR1, bus_if.addR2, bus_if.addWr}, 0);
    check_val("rst_dadowr", bus_if.dadoWr, 0);
    rst = 1'b1;
    bank_init = 1'b0;
    @(negedge clk);
    check_val("ready_after_rst", bus_if.instr_ready, 1);

    // ADD r3,r1,r2
    issue(enc(4'h1, 3'd3, 3'd1, 3'd2), 1'b0, '0);
    check_val("add_busy",    busy1, 1);
    check_val("add_wrcnt",   wr_cnt, 1);
    check_val("add_wrcyc",   wr_cyc, 3);
    check_val("add_addwr",   c_addr, 3);
    check_val("add_dado",    c_dado, 8'h03);
    check_val("add_done",    {done_cnt[3:0], done_cyc[3:0]}, {4'd1, 4'd3});
    check_val("add_erro",    erro_cnt, 0);
    check_val("add_flags",   {c_z, c_c}, 2'b00);
    check_val("add_rdycyc",  rdy_cyc, 4);

    // LDI r5,0xFF then ADD r6,r5,r1
    issue(enc_ldi(3'd5, 8'hFF), 1'b0, '0);
    check_val("ldi_dado",    {c_addr, c_dado}, {3'd5, 8'hFF});
    check_val("ldi_flags",   {c_z, c_c}, 2'b00);
    issue(enc(4'h1, 3'd6, 3'd5, 3'd1), 1'b0, '0);
    check_val("addc_dado",   {c_addr, c_dado}, {3'd6, 8'h00});
    check_val("addc_flags",  {c_z, c_c}, 2'b11);
    check_val("addc_rdycyc", rdy_cyc, 4);
    check_val("bank_r6",     bank[6], 8'h00);

    // SUB r0,r1,r2 then CMP r4,r4
    issue(enc(4'h2, 3'd0, 3'd1, 3'd2), 1'b0, '0);
    check_val("sub_dado",    {c_addr, c_dado}, {3'd0, 8'hFF});
    check_val("sub_flags",   {c_z, c_c}, 2'b01);
    check_val("bank_r0",     bank[0], 8'hFF);
    issue(enc(4'h8, 3'd0, 3'd4, 3'd4), 1'b0, '0);
    check_val("cmp_wrcnt",   wr_cnt, 0);
    check_val("cmp_done",    done_cnt, 1);
    check_val("cmp_flags",   {c_z, c_c}, 2'b10);

    // illegal opcode 0xC, then NOP
    issue(enc(4'hC, 3'd3, 3'd1, 3'd2), 1'b0, '0);
    check_val("ill_done",    {done_cnt[3:0], done_cyc[3:0]}, {4'd1, 4'd3});
    check_val("ill_erro",    {erro_cnt[3:0], erro_cyc[3:0]}, {4'd1, 4'd3});
    check_val("ill_wrcnt",   wr_cnt, 0);
    check_val("ill_flags",   {c_z, c_c}, 2'b10);
    issue(enc(4'h0, 3'd3, 3'd1, 3'd2), 1'b0, '0);
    check_val("nop_done",    done_cnt, 1);
    check_val("nop_erro",    erro_cnt, 0);
    check_val("nop_wrcnt",   wr_cnt, 0);
    check_val("nop_flags",   {c_z, c_c}, 2'b10);

    // back-to-back with instr_valid held: ADD r1,r1,r1 then MOV r2,r1
    issue(enc(4'h1, 3'd1, 3'd1, 3'd1), 1'b1, enc(4'h6, 3'd2, 3'd1, 3'd0));
    check_val("b2b_add",     {c_addr, c_dado}, {3'd1, 8'h02});
    check_val("b2b_rdycyc",  rdy_cyc, 4);
    @(posedge clk);
    observe(1'b0, '0);
    check_val("b2b_mov",     {c_addr, c_dado}, {3'd2, 8'h02});
    check_val("b2b_movflg",  {c_z, c_c}, 2'b00);
    check_val("bank_r1",     bank[1], 8'h02);

    // reset during EXECUTA of ADD r7,r1,r2
    @(negedge clk);
    bus_if.instr_valid = 1'b1;
    bus_if.instr = enc(4'h1, 3'd7, 3'd1, 3'd2);
    wait_ready("accept_r7");
    @(posedge clk);
    @(negedge clk);
    bus_if.instr_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("abort_ex_wren", bus_if.wrEn, 0);
    check_val("abort_ex_done", bus_if.done, 0);
    check_val("abort_ex_busy", bus_if.busy, 0);
    wr_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus_if.wrEn) wr_cnt++;
      if (bus_if.done) done_cnt++;
    end
    check_val("abort_ex_quiet", {wr_cnt[3:0], done_cnt[3:0]}, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_ex_ready", bus_if.instr_ready, 1);
    check_val("bank_r7",        bank[7], 8'h07);

    // reset during ESCRITA of LDI r4,0x5A: wrEn must fall at once, no write
    bus_if.instr_valid = 1'b1;
    bus_if.instr = enc_ldi(3'd4, 8'h5A);
    wait_ready("accept_r4");
    @(posedge clk);
    @(negedge clk);
    bus_if.instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("abort_wr_pre",  bus_if.wrEn, 1);
    #1 rst = 1'b0;
    #1;
    check_val("abort_wr_wren", {bus_if.wrEn, bus_if.done}, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_wr_ready", bus_if.instr_ready, 1);
    check_val("bank_r4",        bank[4], 8'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
